// File: rtl/mar_burst_sequencer_if.sv
// mar_burst_sequencer_if: bus/RAM-side signals of the address sequencer.
// Inputs to the sequencer: iData, iLoad, iInc, iDec, iStart, iLen, iReady.
// Outputs from the sequencer: oData, oValid, oBusy, oDone, oWrap.
// slave modport is the sequencer, master modport is the controller/memory side.
interface mar_burst_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
);
    logic [WIDTH-1:0] iData;
    logic             iLoad;
    logic             iInc;
    logic             iDec;
    logic             iStart;
    logic [LEN_W-1:0] iLen;
    logic             iReady;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             oBusy;
    logic             oDone;
    logic             oWrap;

    modport slave (
        input  iData, iLoad, iInc, iDec, iStart, iLen, iReady,
        output oData, oValid, oBusy, oDone, oWrap
    );

    modport master (
        output iData, iLoad, iInc, iDec, iStart, iLen, iReady,
        input  oData, oValid, oBusy, oDone, oWrap
    );
endinterface

// File: rtl/mar_burst_sequencer.sv
// mar_burst_sequencer: memory address register with load/inc/dec and a STRIDE-stepping burst mode.
// Ports: iClk clock, iReset sync active-high reset, bus (slave modport) carrying
// iData/iLoad/iInc/iDec/iStart/iLen/iReady in and oData/oValid/oBusy/oDone/oWrap out.
module mar_burst_sequencer #(
    parameter int WIDTH  = 16,
    parameter int LEN_W  = 8,
    parameter int STRIDE = 1
) (
    input logic iClk,
    input logic iReset,
    mar_burst_sequencer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    localparam logic [WIDTH-1:0] ONE  = 1;
    localparam logic [WIDTH:0]   STEP = (WIDTH+1)'(STRIDE);

    state_t           state, stateNext;
    logic [WIDTH-1:0] addr, addrNext;
    logic [LEN_W-1:0] remaining, remainingNext;
    logic             wrap, wrapNext;
    logic [WIDTH:0]   beatSum;

    // Carry out of the extended sum flags a wrap past all-ones.
    assign beatSum = {1'b0, addr} + STEP;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= stateNext;
            addr      <= addrNext;
            remaining <= remainingNext;
            wrap      <= wrapNext;
        end
    end

    always_comb begin
        stateNext     = state;
        addrNext      = addr;
        remainingNext = remaining;
        wrapNext      = wrap;
        case (state)
            IDLE: begin
                if (bus.iLoad) begin
                    addrNext = bus.iData;
                    wrapNext = 1'b0;
                end else if (bus.iInc && !bus.iStart) begin
                    addrNext = addr + ONE;
                    wrapNext = wrap | (&addr);
                end else if (bus.iDec && !bus.iStart) begin
                    addrNext = addr - ONE;
                    wrapNext = wrap | ~(|addr);
                end
                if (bus.iStart) begin
                    stateNext     = (bus.iLen != '0) ? BURST : DONE;
                    remainingNext = bus.iLen;
                end
            end
            BURST: begin
                if (bus.iReady) begin
                    addrNext      = beatSum[WIDTH-1:0];
                    wrapNext      = wrap | beatSum[WIDTH];
                    remainingNext = remaining - 1'b1;
                    stateNext     = (remaining == 1) ? DONE : BURST;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.oData  = addr;
    assign bus.oValid = state == BURST;
    assign bus.oBusy  = state == BURST;
    assign bus.oDone  = state == DONE;
    assign bus.oWrap  = wrap;
endmodule

// File: tb/tb_mar_burst_sequencer.sv
// tb_mar_burst_sequencer: directed self-checking bench for mar_burst_sequencer (WIDTH=16, LEN_W=8, STRIDE=1).
module tb_mar_burst_sequencer;
    logic iClk = 1'b0;
    logic iReset;
    int   nCompared = 0;
    int   nMismatched = 0;

    mar_burst_sequencer_if #(.WIDTH(16), .LEN_W(8)) bus ();

    mar_burst_sequencer #(.WIDTH(16), .LEN_W(8), .STRIDE(1)) dut (
        .iClk  (iClk),
        .iReset(iReset),
        .bus   (bus)
    );

    always #5 iClk = ~iClk;

    // Advance one edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idleInputs();
        bus.iData  = '0;
        bus.iLoad  = 1'b0;
        bus.iInc   = 1'b0;
        bus.iDec   = 1'b0;
        bus.iStart = 1'b0;
        bus.iLen   = '0;
        bus.iReady = 1'b1;
    endtask

    task automatic loadAddr(input logic [15:0] a);
        bus.iData = a;
        bus.iLoad = 1'b1;
        tick();
        bus.iLoad = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        iReset = 1'b1;
        tick();
        tick();
        iReset = 1'b0;
        nCompared++;
        if ({bus.oData, bus.oValid, bus.oBusy, bus.oDone, bus.oWrap} !== 20'h0) begin
            nMismatched++;
            $display("FAIL reset: got data=%h v=%b b=%b d=%b w=%b, want all zero",
                     bus.oData, bus.oValid, bus.oBusy, bus.oDone, bus.oWrap);
        end
    endtask

    task automatic test_load_hold();
        loadAddr(16'h1234);
        nCompared++;
        if (bus.oData !== 16'h1234 || bus.oWrap !== 1'b0) begin
            nMismatched++;
            $display("FAIL load: got data=%h wrap=%b, want 1234 0", bus.oData, bus.oWrap);
        end
        for (int i = 0; i < 5; i++) tick();
        nCompared++;
        if (bus.oData !== 16'h1234) begin
            nMismatched++;
            $display("FAIL hold: got %h, want 1234", bus.oData);
        end
    endtask

    task automatic test_inc_dec_wrap();
        loadAddr(16'hFFFF);
        bus.iInc = 1'b1;
        bus.iDec = 1'b1;
        tick();
        bus.iInc = 1'b0;
        bus.iDec = 1'b0;
        nCompared++;
        if (bus.oData !== 16'h0000 || bus.oWrap !== 1'b1) begin
            nMismatched++;
            $display("FAIL inc_wrap: got data=%h wrap=%b, want 0000 1", bus.oData, bus.oWrap);
        end
        bus.iDec = 1'b1;
        tick();
        bus.iDec = 1'b0;
        nCompared++;
        if (bus.oData !== 16'hFFFF || bus.oWrap !== 1'b1) begin
            nMismatched++;
            $display("FAIL dec_wrap: got data=%h wrap=%b, want ffff 1", bus.oData, bus.oWrap);
        end
        loadAddr(16'h0010);
        nCompared++;
        if (bus.oData !== 16'h0010 || bus.oWrap !== 1'b0) begin
            nMismatched++;
            $display("FAIL load_clears_wrap: got data=%h wrap=%b, want 0010 0", bus.oData, bus.oWrap);
        end
        bus.iDec = 1'b1;
        tick();
        bus.iDec = 1'b0;
        nCompared++;
        if (bus.oData !== 16'h000F || bus.oWrap !== 1'b0) begin
            nMismatched++;
            $display("FAIL dec: got data=%h wrap=%b, want 000f 0", bus.oData, bus.oWrap);
        end
    endtask

    task automatic test_burst();
        loadAddr(16'h0100);
        bus.iStart = 1'b1;
        bus.iLen   = 8'd4;
        bus.iInc   = 1'b1;
        tick();
        bus.iStart = 1'b0;
        bus.iInc   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            nCompared++;
            if (bus.oValid !== 1'b1 || bus.oBusy !== 1'b1 || bus.oDone !== 1'b0 ||
                bus.oData !== 16'h0100 + 16'(k)) begin
                nMismatched++;
                $display("FAIL burst_beat%0d: got data=%h v=%b b=%b d=%b, want %h 1 1 0",
                         k, bus.oData, bus.oValid, bus.oBusy, bus.oDone, 16'h0100 + 16'(k));
            end
            tick();
        end
        nCompared++;
        if (bus.oDone !== 1'b1 || bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oData !== 16'h0104) begin
            nMismatched++;
            $display("FAIL burst_done: got data=%h d=%b v=%b b=%b, want 0104 1 0 0",
                     bus.oData, bus.oDone, bus.oValid, bus.oBusy);
        end
        tick();
        nCompared++;
        if (bus.oDone !== 1'b0 || bus.oValid !== 1'b0 || bus.oData !== 16'h0104) begin
            nMismatched++;
            $display("FAIL burst_idle: got data=%h d=%b v=%b, want 0104 0 0", bus.oData, bus.oDone, bus.oValid);
        end
    endtask

    task automatic test_stall();
        logic [15:0] expData [6] = '{16'h0100, 16'h0101, 16'h0101, 16'h0101, 16'h0102, 16'h0103};
        int beats = 0;
        int cyc = 0;
        loadAddr(16'h0100);
        bus.iStart = 1'b1;
        bus.iLen   = 8'd4;
        tick();
        bus.iStart = 1'b0;
        while (!bus.oDone && cyc < 20) begin
            bus.iReady = !(cyc == 1 || cyc == 2);
            if (cyc < 6) begin
                nCompared++;
                if (bus.oData !== expData[cyc] || bus.oValid !== 1'b1) begin
                    nMismatched++;
                    $display("FAIL stall_cycle%0d: got data=%h v=%b, want %h 1",
                             cyc, bus.oData, bus.oValid, expData[cyc]);
                end
            end
            if (bus.oValid && bus.iReady) beats++;
            tick();
            cyc++;
        end
        bus.iReady = 1'b1;
        nCompared++;
        if (cyc !== 6 || beats !== 4 || bus.oData !== 16'h0104) begin
            nMismatched++;
            $display("FAIL stall_done: got done_cycle=%0d beats=%0d data=%h, want 6 4 0104",
                     cyc, beats, bus.oData);
        end
        tick();
    endtask

    task automatic test_load_start_wrap();
        logic [15:0] expData [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        logic        expWrap [3] = '{1'b0, 1'b0, 1'b1};
        loadAddr(16'h0040);
        bus.iData  = 16'hFFFE;
        bus.iLoad  = 1'b1;
        bus.iStart = 1'b1;
        bus.iLen   = 8'd3;
        tick();
        bus.iLoad  = 1'b0;
        bus.iStart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nCompared++;
            if (bus.oData !== expData[k] || bus.oWrap !== expWrap[k] || bus.oValid !== 1'b1) begin
                nMismatched++;
                $display("FAIL ldstart_beat%0d: got data=%h w=%b v=%b, want %h %b 1",
                         k, bus.oData, bus.oWrap, bus.oValid, expData[k], expWrap[k]);
            end
            tick();
        end
        nCompared++;
        if (bus.oDone !== 1'b1 || bus.oData !== 16'h0001 || bus.oWrap !== 1'b1) begin
            nMismatched++;
            $display("FAIL ldstart_done: got data=%h d=%b w=%b, want 0001 1 1", bus.oData, bus.oDone, bus.oWrap);
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        int doneSeen = 0;
        loadAddr(16'h0200);
        bus.iStart = 1'b1;
        bus.iLen   = 8'd8;
        tick();
        bus.iStart = 1'b0;
        tick();
        tick();
        iReset = 1'b1;
        tick();
        iReset = 1'b0;
        nCompared++;
        if ({bus.oData, bus.oValid, bus.oBusy, bus.oDone, bus.oWrap} !== 20'h0) begin
            nMismatched++;
            $display("FAIL mid_reset: got data=%h v=%b b=%b d=%b w=%b, want all zero",
                     bus.oData, bus.oValid, bus.oBusy, bus.oDone, bus.oWrap);
        end
        for (int i = 0; i < 12; i++) begin
            if (bus.oDone || bus.oValid) doneSeen++;
            tick();
        end
        nCompared++;
        if (doneSeen !== 0) begin
            nMismatched++;
            $display("FAIL mid_reset_quiet: got %0d cycles with done/valid, want 0", doneSeen);
        end
    endtask

    task automatic test_zero_len();
        loadAddr(16'h0055);
        bus.iStart = 1'b1;
        bus.iLen   = 8'd0;
        tick();
        bus.iStart = 1'b0;
        nCompared++;
        if (bus.oDone !== 1'b1 || bus.oValid !== 1'b0 || bus.oBusy !== 1'b0 || bus.oData !== 16'h0055) begin
            nMismatched++;
            $display("FAIL zero_len: got data=%h d=%b v=%b b=%b, want 0055 1 0 0",
                     bus.oData, bus.oDone, bus.oValid, bus.oBusy);
        end
        tick();
        nCompared++;
        if (bus.oDone !== 1'b0 || bus.oValid !== 1'b0 || bus.oData !== 16'h0055) begin
            nMismatched++;
            $display("FAIL zero_len_after: got data=%h d=%b v=%b, want 0055 0 0", bus.oData, bus.oDone, bus.oValid);
        end
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_inc_dec_wrap();
        test_burst();
        test_stall();
        test_load_start_wrap();
        test_reset_mid_burst();
        test_zero_len();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
